// File: rtl/fsm_1011_pkg.sv
// Shared definitions for the 1011 Moore sequence detector: state codes and
// the small decode helper used by the output logic.
package fsm_1011_pkg;

  localparam int STATE_W = 3;

  // Codes 5..7 are never entered in normal operation and are treated as illegal.
  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,  // idle, no partial match
    S1 = 3'd1,  // seen "1"
    S2 = 3'd2,  // seen "10"
    S3 = 3'd3,  // seen "101"
    S4 = 3'd4   // seen "1011", detection
  } state_t;

  // Detection flag is a pure decode of the (next) state code.
  function automatic logic is_detect(input state_t s);
    return (s == S4);
  endfunction

endpackage

// File: rtl/fsm_1011_moore_sat_counter.sv
// Saturating up-counter with a synchronous clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_r;

  // Count register: clear has priority, increment only while below the ceiling.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != {WIDTH{1'b1}})) begin
      cnt_r <= cnt_r + WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/fsm_1011_moore.sv
// Moore detector for the serial pattern 1011 (first bit first), non-overlapping.
// After a detection the matcher restarts from idle context; a saturating
// counter tallies detections since the last reset.
module fsm_1011_moore
  import fsm_1011_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN,
  output logic             OUT,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] MATCH_CNT
);

  state_t state_r;
  state_t next_state_s;
  logic   out_r;
  logic   enter_s;

  // Next-state logic; any illegal code falls back to idle.
  always_comb begin
    next_state_s = S0;
    case (state_r)
      S0: begin
        if (IN) next_state_s = S1;
        else    next_state_s = S0;
      end
      S1: begin
        if (IN) next_state_s = S1;
        else    next_state_s = S2;
      end
      S2: begin
        if (IN) next_state_s = S3;
        else    next_state_s = S0;
      end
      S3: begin
        if (IN) next_state_s = S4;
        else    next_state_s = S2;
      end
      S4: begin
        // No reuse of the detected bits: restart as if from idle.
        if (IN) next_state_s = S1;
        else    next_state_s = S0;
      end
      default: begin
        next_state_s = S0;
      end
    endcase
  end

  // Counter strobe: asserted on the edge that moves into the detect state.
  always_comb begin
    enter_s = 1'b0;
    if ((next_state_s == S4) && (state_r != S4)) begin
      enter_s = 1'b1;
    end else begin
      enter_s = 1'b0;
    end
  end

  // State and output registers; OUT is registered alongside the state so it
  // always equals the S4 decode of STATE and cannot glitch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S0;
      out_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      out_r   <= is_detect(next_state_s);
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk (CLK),
    .clr (RST),
    .inc (enter_s),
    .cnt (MATCH_CNT)
  );

  assign OUT   = out_r;
  assign STATE = state_r;

endmodule

// File: tb/tb_fsm_1011_moore.sv
// Self-checking bench for fsm_1011_moore. Two instances share stimulus: the
// default 8-bit counter and a 2-bit counter for saturation. Expected values
// come from a pattern-matching model over the received bit history.
module tb_fsm_1011_moore;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       out8, out2;
  logic [2:0] state8, state2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit hist[$];
  int exp_state = 0;
  int exp_cnt8  = 0;
  int exp_cnt2  = 0;
  int pulses    = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  fsm_1011_moore #(.CNT_W(8)) dut8 (
    .CLK(clk), .RST(rst), .IN(in_bit),
    .OUT(out8), .STATE(state8), .MATCH_CNT(cnt8)
  );

  fsm_1011_moore #(.CNT_W(2)) dut2 (
    .CLK(clk), .RST(rst), .IN(in_bit),
    .OUT(out2), .STATE(state2), .MATCH_CNT(cnt2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Length of the longest suffix of the history that is a proper prefix of 1011.
  function automatic int prefix_len();
    for (int k = 3; k >= 1; k--) begin
      if (hist.size() >= k) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (hist[hist.size() - k + i] != pat[i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic bit ends_with_pattern();
    if (hist.size() < 4) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (hist[hist.size() - 4 + i] != pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive on the falling edge, update the model, check after the rising edge.
  task automatic step(input bit r, input bit b);
    @(negedge clk);
    rst    = r;
    in_bit = b;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      exp_state = 0;
      exp_cnt8  = 0;
      exp_cnt2  = 0;
    end else begin
      hist.push_back(b);
      if (ends_with_pattern()) begin
        exp_state = 4;
        if (exp_cnt8 < 255) exp_cnt8++;
        if (exp_cnt2 < 3)   exp_cnt2++;
        hist.delete();
      end else begin
        exp_state = prefix_len();
      end
    end
    if (out8 === 1'b1) pulses++;
    check_eq("state8", 32'(state8), 32'(exp_state));
    check_eq("out8",   32'(out8),   32'(exp_state == 4));
    check_eq("cnt8",   32'(cnt8),   32'(exp_cnt8));
    check_eq("state2", 32'(state2), 32'(exp_state));
    check_eq("out2",   32'(out2),   32'(exp_state == 4));
    check_eq("cnt2",   32'(cnt2),   32'(exp_cnt2));
  endtask

  // Apply n bits of v, most significant bit first.
  task automatic run_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, v[i]);
  endtask

  task automatic do_reset(input int edges);
    for (int i = 0; i < edges; i++) step(1'b1, 1'b0);
    pulses = 0;
  endtask

  initial begin
    rst    = 1'b1;
    in_bit = 1'b0;

    // Reset sequence followed by a single pattern.
    do_reset(2);
    check_eq("reset_state", 32'(state8), 32'd0);
    check_eq("reset_cnt",   32'(cnt8),   32'd0);
    check_eq("reset_out",   32'(out8),   32'd0);
    run_bits(32'b1011, 4);
    check_eq("first_pulse", 32'(out8), 32'd1);
    check_eq("first_cnt",   32'(cnt8), 32'd1);
    step(1'b0, 1'b0);
    check_eq("pulse_width", 32'(out8), 32'd0);

    // Non-overlap: 1011011 yields only one detection.
    do_reset(1);
    run_bits(32'b1011011, 7);
    check_eq("nonoverlap_pulses", 32'(pulses), 32'd1);
    check_eq("nonoverlap_cnt",    32'(cnt8),   32'd1);

    // Long stream with detections after bits 4, 11, 16, 21.
    do_reset(1);
    run_bits(32'b101101110110101111011, 21);
    check_eq("long_pulses", 32'(pulses), 32'd4);
    check_eq("long_cnt",    32'(cnt8),   32'd4);

    // Reset in the middle of a partial match.
    do_reset(1);
    run_bits(32'b101, 3);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check_eq("midreset_pulses", 32'(pulses), 32'd0);
    check_eq("midreset_state",  32'(state8), 32'd1);

    // Saturation of the 2-bit counter across five detections.
    do_reset(1);
    for (int i = 0; i < 5; i++) run_bits(32'b1011, 4);
    check_eq("sat_cnt2", 32'(cnt2), 32'd3);
    check_eq("sat_cnt8", 32'(cnt8), 32'd5);

    // Noise: constant zeros, then constant ones.
    do_reset(1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    check_eq("zeros_pulses", 32'(pulses), 32'd0);
    check_eq("zeros_state",  32'(state8), 32'd0);
    do_reset(1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check_eq("ones_pulses", 32'(pulses), 32'd0);
    check_eq("ones_state",  32'(state8), 32'd1);

    // Randomized stream with occasional resets.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_1011_moore.md
FSM_1011_MOORE -- requirements
Module: fsm_1011_moore

Interface
REQ-001 Parameter: CNT_W, default 8, width of the match counter output.
REQ-002 Port: CLK  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 Port: RST  input  1  reset; synchronous and active-high (sampled only on rising CLK).
REQ-004 Port: IN  input  1  serial data bit, sampled on each rising CLK edge.
REQ-005 Port: OUT  output  1  detection flag; high for exactly one cycle per detected 1011.
REQ-006 Port: STATE  output  3  current state encoding, for debug.
REQ-007 Port: MATCH_CNT  output  CNT_W  number of detections since reset, saturating.

Function
REQ-008 Block SHALL be a Moore detector of serial pattern 1011 (first-received bit first), non-overlapping.
REQ-009 States and encodings: S0=0 idle, S1=1 "1", S2=2 "10", S3=3 "101", S4=4 "1011" detected; codes 5-7 illegal.
REQ-010 Transitions IN=0/IN=1: S0->S0/S1; S1->S2/S1; S2->S0/S3; S3->S2/S4; S4->S0/S1.
REQ-011 Non-overlap: after S4, no bits of the detected pattern are reused; matching restarts from S0 context.
REQ-012 Illegal state codes SHALL transition to S0 on the next edge with OUT=0.
REQ-013 OUT SHALL be 1 iff STATE==S4; it is a pure state decode, independent of the current IN, and glitch-free.
REQ-014 Latency: OUT rises in the cycle immediately after the edge that samples the 4th pattern bit; lasts one cycle.
REQ-015 Back-to-back detections are impossible in consecutive cycles; minimum spacing is 4 cycles.
REQ-016 MATCH_CNT SHALL increment by 1 on every edge that enters S4; it saturates at 2^CNT_W-1 with no wrap.
REQ-017 STATE SHALL equal the registered state code.

Reset
REQ-018 While RST=1 at a rising edge: state<=S0 and MATCH_CNT<=0; OUT=0 from the following cycle.
REQ-019 RST has priority over IN; any partial match in progress is discarded.
REQ-020 After RST deasserts, the first bit sampled is treated as the first bit of a new sequence.
REQ-021 State before the first reset edge is undefined; no power-up value is required.

Structure
REQ-022 State encodings (S0-S4) SHALL be defined as named constants in a shared package, fsm_1011_pkg.
REQ-023 The saturating counter SHALL be one sub-module, sat_counter, parameterized by width, with inc and sync clear inputs.
REQ-024 The FSM SHALL be a single registered state vector with separate combinational next-state and output logic.

Verification
REQ-025 Reset sequence: RST=1 for 2 edges, then IN=1,0,1,1 -> OUT=1 in cycle 5 only; MATCH_CNT=1.
REQ-026 Non-overlap case: after reset, IN=1,0,1,1,0,1,1 -> exactly one OUT pulse (after bit 4); no pulse after bit 7; MATCH_CNT=1.
REQ-027 Long stream: after reset, IN=1,0,1,1,0,1,1,1,0,1,1,0,1,0,1,1,1,1,0,1,1 -> OUT pulses after bits 4, 11, 16, 21; MATCH_CNT=4.
REQ-028 Reset mid-match: IN=1,0,1, then RST=1 for 1 edge, then IN=1 -> no pulse; STATE=S1.
REQ-029 Saturation: with CNT_W=2, 5 separate 1011 detections -> MATCH_CNT stays at 3.
REQ-030 Noise: IN all 0 or all 1 for 20 cycles -> OUT stays 0; STATE stays S0 (all 0) or S1 (all 1).
